// File: rtl/acc_column.sv
// acc_column: column accumulator behind the bottom PE of one systolic-array column.
// Valid partial sums are added in place into a DEPTH-entry buffer, so several
// weight tiles accumulate into the same entries. A drain request streams the
// buffer out in order over valid/ready and zeroes each entry as it is read.
// Optional build macro: ACC_SATURATE_EN -- when defined, the accumulate add
// saturates at the signed limits of ACC_WIDTH instead of wrapping.
module acc_column #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int SUM_WIDTH  = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SUM_WIDTH-1:0] sumin,
  input  logic                 activein,
  input  logic                 drain,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 pass_done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ACC_WIDTH-1:0]  mem [DEPTH];

  logic [ACC_WIDTH-1:0]  sum_ext;
  logic [ACC_WIDTH-1:0]  cur_entry;
  logic [ACC_WIDTH-1:0]  add_result;
  logic                  wr_en;
  logic                  clr_en;

  // Writes are only accepted while not draining; a sample in DRAIN is dropped.
  assign wr_en       = activein && (state != DRAIN);
  assign clr_en      = (state == DRAIN) && dout_valid && dout_ready;
  assign rd_ptr_next = rd_ptr + 1'b1;
  assign sum_ext     = {{(ACC_WIDTH - SUM_WIDTH){sumin[SUM_WIDTH-1]}}, sumin};
  assign cur_entry   = mem[wr_ptr];
  assign busy        = (state != IDLE);

`ifdef ACC_SATURATE_EN
  logic [ACC_WIDTH:0] raw_sum;

  // Saturating add: one guard bit exposes signed overflow, then clamp to the rail
  // indicated by the true (guard) sign.
  always_comb begin
    raw_sum    = {cur_entry[ACC_WIDTH-1], cur_entry} + {sum_ext[ACC_WIDTH-1], sum_ext};
    add_result = raw_sum[ACC_WIDTH-1:0];
    if (raw_sum[ACC_WIDTH] != raw_sum[ACC_WIDTH-1]) begin
      if (raw_sum[ACC_WIDTH]) begin
        add_result = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
      end else begin
        add_result = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
      end
    end
  end
`else
  // Wrapping two's-complement add, modulo 2^ACC_WIDTH.
  always_comb begin
    add_result = cur_entry + sum_ext;
  end
`endif

  // Buffer storage: accumulate at wr_ptr, clear at rd_ptr on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= add_result;
    end else if (clr_en) begin
      mem[rd_ptr] <= '0;
    end
  end

  // Control FSM with registered stream outputs, pass pulse and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pass_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          // A sample beats a simultaneous drain request; the drain is dropped.
          if (activein) begin
            wr_ptr <= wr_ptr + 1'b1;
            state  <= FILL;
          end else if (drain) begin
            rd_ptr     <= '0;
            dout       <= mem[0];
            dout_valid <= 1'b1;
            state      <= DRAIN;
          end
        end
        FILL: begin
          // Gaps in activein simply hold wr_ptr; drain has no effect here.
          if (activein) begin
            if (wr_ptr == LAST_ADDR) begin
              wr_ptr    <= '0;
              pass_done <= 1'b1;
              state     <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (activein) begin
            err <= 1'b1;
          end
          // dout only moves on an accepted beat, so it holds under back-pressure.
          if (dout_valid && dout_ready) begin
            if (rd_ptr == LAST_ADDR) begin
              rd_ptr     <= '0;
              dout       <= '0;
              dout_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              rd_ptr <= rd_ptr_next;
              dout   <= mem[rd_ptr_next];
            end
          end
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_column.sv
// Bench for acc_column: directed passes and drains against a software buffer
// model; drained values are queued as expectations and popped per accepted beat.
`timescale 1ns/1ps
module tb_acc_column;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sumin = '0;
  logic        activein = 1'b0;
  logic        drain = 1'b0;
  logic        dout_ready = 1'b0;
  logic [23:0] dout;
  logic        dout_valid, busy, pass_done, err;
  logic [16:0] dout17;
  logic        dout_valid17, busy17, pass_done17, err17;

  always #5 clk = ~clk;

  acc_column #(.DEPTH(16), .ADDR_WIDTH(4), .SUM_WIDTH(16), .ACC_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .sumin(sumin), .activein(activein), .drain(drain),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .pass_done(pass_done), .err(err)
  );

  acc_column #(.DEPTH(16), .ADDR_WIDTH(4), .SUM_WIDTH(16), .ACC_WIDTH(17)) dut17 (
    .clk(clk), .reset(reset), .sumin(sumin), .activein(activein), .drain(drain),
    .dout(dout17), .dout_valid(dout_valid17), .dout_ready(dout_ready),
    .busy(busy17), .pass_done(pass_done17), .err(err17)
  );

  logic [23:0] model [DEPTH];
  logic [23:0] exp_q [$];
  logic [16:0] exp17 = '0;
  bit          chk17 = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; activein = 1'b0; drain = 1'b0; dout_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic send_pass(input logic [15:0] base, input logic [15:0] incr,
                           input bit gaps, input bit drain_first);
    for (int i = 0; i < DEPTH; i++) begin
      sumin    = base + 16'(i) * incr;
      activein = 1'b1;
      drain    = (drain_first && i == 0);
      model[i] = model[i] + {{8{sumin[15]}}, sumin};
      step();
      activein = 1'b0;
      drain    = 1'b0;
      if (drain_first && i == 0) begin
        chk("sample_beats_drain_valid", {31'd0, dout_valid}, 32'd0);
        chk("sample_beats_drain_busy", {31'd0, busy}, 32'd1);
      end
      if (i < DEPTH - 1) chk("pass_done_early", {31'd0, pass_done}, 32'd0);
      else               chk("pass_done_pulse", {31'd0, pass_done}, 32'd1);
      if (gaps && (i % 4 == 1)) begin
        drain = 1'b1;
        step();
        drain = 1'b0;
        chk("fill_drain_ignored", {31'd0, dout_valid}, 32'd0);
        chk("fill_busy", {31'd0, busy}, 32'd1);
      end
    end
    chk("busy_after_pass", {31'd0, busy}, 32'd0);
    step();
    chk("pass_done_single", {31'd0, pass_done}, 32'd0);
  endtask

  task automatic do_drain(input int mode, input int err_at);
    int          accepted;
    int          cyc;
    logic [23:0] held;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(model[i]);
      model[i] = '0;
    end
    drain = 1'b1;
    step();
    drain = 1'b0;
    chk("valid_first", {31'd0, dout_valid}, 32'd1);
    chk("busy_drain", {31'd0, busy}, 32'd1);
    accepted = 0;
    cyc = 0;
    held = dout;
    while (accepted < DEPTH && cyc < 200) begin
      chk("valid_hold", {31'd0, dout_valid}, 32'd1);
      if (dout_valid !== 1'b1) break;
      dout_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      activein   = (cyc == err_at);
      sumin      = 16'h1111;
      if (dout_ready) begin
        chk("dout", {8'd0, dout}, {8'd0, exp_q.pop_front()});
        if (chk17) chk("dout17", {15'd0, dout17}, {15'd0, exp17});
        $display("beat %0d: dout=%h", accepted, dout);
        accepted++;
      end else begin
        held = dout;
      end
      step();
      activein = 1'b0;
      if (!dout_ready) chk("dout_stable", {8'd0, dout}, {8'd0, held});
      if (err_at >= 0 && cyc == err_at) chk("err_set", {31'd0, err}, 32'd1);
      cyc++;
    end
    dout_ready = 1'b0;
    chk("drain_accept_count", accepted, DEPTH);
    chk("valid_after", {31'd0, dout_valid}, 32'd0);
    chk("busy_after_drain", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {8'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pass_done", {31'd0, pass_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst17", {28'd0, dout_valid17, busy17, pass_done17, err17}, 32'd0);

    // Pass of 1..16, drain at full rate.
    send_pass(16'd1, 16'd1, 1'b0, 1'b0);
    do_drain(0, -1);
    chk("err_clean", {31'd0, err}, 32'd0);

    // Three passes of 0x0100 accumulate, then one pass of 5 with gaps.
    for (int p = 0; p < 3; p++) send_pass(16'h0100, 16'd0, 1'b0, 1'b0);
    do_drain(0, -1);
    send_pass(16'd5, 16'd0, 1'b1, 1'b0);
    do_drain(0, -1);

    // Sign extension: two passes of -1.
    send_pass(16'hFFFF, 16'd0, 1'b0, 1'b0);
    send_pass(16'hFFFF, 16'd0, 1'b0, 1'b0);
    do_drain(0, -1);

    // Mixed-sign values, first sample collides with drain, toggling ready.
    send_pass(16'hFF00, 16'h0777, 1'b0, 1'b1);
    do_drain(1, -1);

    // Sample during drain is dropped and latches err.
    send_pass(16'h0020, 16'd3, 1'b0, 1'b0);
    do_drain(0, 5);
    chk("err_sticky", {31'd0, err}, 32'd1);
    step();
    chk("err_sticky2", {31'd0, err}, 32'd1);

    // Reset in the middle of a fill pass.
    for (int i = 0; i < 7; i++) begin
      sumin = 16'd9;
      activein = 1'b1;
      step();
    end
    activein = 1'b0;
    chk("mid_fill_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_err", {31'd0, err}, 32'd0);
    chk("rst_mid_valid", {31'd0, dout_valid}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    do_drain(0, -1);

    // Narrow accumulator: three passes of 0x7FFF.
    do_reset();
`ifdef ACC_SATURATE_EN
    exp17 = 17'h0FFFF;
`else
    exp17 = 17'h17FFD;
`endif
    chk17 = 1'b1;
    for (int p = 0; p < 3; p++) send_pass(16'h7FFF, 16'd0, 1'b0, 1'b0);
    do_drain(0, -1);
    chk17 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
